// File: rtl/alu_pipe_core.sv
// Multi-mode ALU that collects split operands, runs single-cycle ops immediately
// and multiplies over MUL_LAT cycles, reporting each result with a RES_VALID pulse.
module alu_pipe_core #(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 4,
  parameter int TIMEOUT    = 16,
  parameter int MUL_LAT    = 3
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    CE,
  input  logic                    MODE,
  input  logic [CMD_WIDTH-1:0]    CMD,
  input  logic [DATA_WIDTH-1:0]   OPA,
  input  logic [DATA_WIDTH-1:0]   OPB,
  input  logic                    CIN,
  input  logic [1:0]              INP_VALID,
  output logic                    READY,
  output logic                    RES_VALID,
  output logic [2*DATA_WIDTH-1:0] RES,
  output logic                    COUT,
  output logic                    OFLOW,
  output logic                    G,
  output logic                    E,
  output logic                    L,
  output logic                    ERR
);

  localparam int W  = DATA_WIDTH;
  localparam int RW = 2 * DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int MW = $clog2(MUL_LAT) + 1;
  localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B, MUL} state_t;

  state_t             state, state_n;
  logic [TW-1:0]      timer;
  logic [MW-1:0]      mcnt;
  logic [W-1:0]       lat_a, lat_b;
  logic [CMD_WIDTH-1:0] lat_cmd;
  logic               lat_mode, lat_cin;
  logic [RW-1:0]      mul_prod;

  logic [W-1:0]       eff_a, eff_b;
  logic [CMD_WIDTH-1:0] eff_cmd;
  logic               eff_mode, eff_cin;
  int unsigned        code;
  logic               need_a, need_b, cmd_ok, is_mul;

  logic [RW-1:0]      x_res;
  logic               x_cout, x_oflow, x_g, x_e, x_l, x_err;
  logic [W:0]         ax, bx, cx, t, ts, ma, mb;
  logic [W-1:0]       lr;
  logic [2*W-1:0]     dbl;
  logic [RW-1:0]      mul_p;

  logic issue, capture, tick_t, time_out, mul_done;

  // In a wait state the held operand and command come from the latches, the arriving one from the port.
  always_comb begin
    eff_a    = (state == WAIT_B) ? lat_a : OPA;
    eff_b    = (state == WAIT_A) ? lat_b : OPB;
    eff_cmd  = (state == IDLE) ? CMD  : lat_cmd;
    eff_mode = (state == IDLE) ? MODE : lat_mode;
    eff_cin  = (state == IDLE) ? CIN  : lat_cin;
    code     = 32'(eff_cmd);
  end

  always_comb begin
    need_a = 1'b0;
    need_b = 1'b0;
    cmd_ok = 1'b1;
    is_mul = 1'b0;
    if (eff_mode) begin
      case (code)
        0, 1, 2, 3, 8, 11, 12: begin need_a = 1'b1; need_b = 1'b1; end
        9, 10:                 begin need_a = 1'b1; need_b = 1'b1; is_mul = 1'b1; end
        4, 5:                  need_a = 1'b1;
        6, 7:                  need_b = 1'b1;
        default:               cmd_ok = 1'b0;
      endcase
    end else begin
      case (code)
        0, 1, 2, 3, 4, 5, 12, 13: begin need_a = 1'b1; need_b = 1'b1; end
        6, 8, 9:                  need_a = 1'b1;
        7, 10, 11:                need_b = 1'b1;
        default:                  cmd_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    ax = {1'b0, eff_a};
    bx = {1'b0, eff_b};
    cx = {{W{1'b0}}, eff_cin};
    if (code == 9) begin
      ma = ax + ONE;
      mb = bx + ONE;
    end else begin
      ma = {eff_a, 1'b0};
      mb = bx;
    end
    mul_p = {{(RW-W-1){1'b0}}, ma} * {{(RW-W-1){1'b0}}, mb};
  end

  always_comb begin
    x_res   = '0;
    x_cout  = 1'b0;
    x_oflow = 1'b0;
    x_g     = 1'b0;
    x_e     = 1'b0;
    x_l     = 1'b0;
    x_err   = 1'b0;
    t       = '0;
    ts      = '0;
    lr      = '0;
    dbl     = '0;
    if (eff_mode) begin
      case (code)
        0: begin t = ax + bx;      x_cout = t[W]; x_res = {{(RW-W-1){1'b0}}, t}; end
        1: begin t = ax - bx;      x_cout = t[W]; x_oflow = (ax < bx);
                 x_res = {{(RW-W-1){1'b0}}, t}; end
        2: begin t = ax + bx + cx; x_cout = t[W]; x_res = {{(RW-W-1){1'b0}}, t}; end
        3: begin t = ax - bx - cx; x_cout = t[W]; x_oflow = (ax < (bx + cx));
                 x_res = {{(RW-W-1){1'b0}}, t}; end
        4: begin t = ax + ONE;     x_res = {{(RW-W-1){1'b0}}, t}; end
        5: begin t = ax - ONE;     x_res = {{(RW-W-1){1'b0}}, t}; end
        6: begin t = bx + ONE;     x_res = {{(RW-W-1){1'b0}}, t}; end
        7: begin t = bx - ONE;     x_res = {{(RW-W-1){1'b0}}, t}; end
        8: begin x_g = (eff_a > eff_b); x_e = (eff_a == eff_b); x_l = (eff_a < eff_b); end
        9, 10: x_res = mul_p;
        11, 12: begin
          ts = (code == 11) ? ({eff_a[W-1], eff_a} + {eff_b[W-1], eff_b})
                            : ({eff_a[W-1], eff_a} - {eff_b[W-1], eff_b});
          // Overflow is judged on the DATA_WIDTH-bit result; RES keeps the sign-extended extra bit.
          x_oflow = (code == 11) ? ((eff_a[W-1] == eff_b[W-1]) && (ts[W-1] != eff_a[W-1]))
                                 : ((eff_a[W-1] != eff_b[W-1]) && (ts[W-1] != eff_a[W-1]));
          x_g   = ($signed(eff_a) >  $signed(eff_b));
          x_e   = (eff_a == eff_b);
          x_l   = ($signed(eff_a) <  $signed(eff_b));
          x_res = {{(RW-W-1){1'b0}}, ts};
        end
        default: x_err = 1'b1;
      endcase
    end else begin
      case (code)
        0:  lr = eff_a & eff_b;
        1:  lr = ~(eff_a & eff_b);
        2:  lr = eff_a | eff_b;
        3:  lr = ~(eff_a | eff_b);
        4:  lr = eff_a ^ eff_b;
        5:  lr = ~(eff_a ^ eff_b);
        6:  lr = ~eff_a;
        7:  lr = ~eff_b;
        8:  lr = eff_a >> 1;
        9:  lr = eff_a << 1;
        10: lr = eff_b >> 1;
        11: lr = eff_b << 1;
        12: begin dbl = {eff_a, eff_a} << eff_b[SW-1:0]; lr = dbl[2*W-1:W]; x_err = |eff_b[W-1:SW]; end
        13: begin dbl = {eff_a, eff_a} >> eff_b[SW-1:0]; lr = dbl[W-1:0];   x_err = |eff_b[W-1:SW]; end
        default: x_err = 1'b1;
      endcase
      x_res = {{(RW-W){1'b0}}, lr};
    end
  end

  always_comb begin
    state_n  = state;
    issue    = 1'b0;
    capture  = 1'b0;
    tick_t   = 1'b0;
    time_out = 1'b0;
    mul_done = 1'b0;
    case (state)
      IDLE: begin
        if (!cmd_ok) begin
          issue = |INP_VALID;
        end else if (need_a && need_b) begin
          case (INP_VALID)
            2'b11:   issue = 1'b1;
            2'b01:   begin capture = 1'b1; state_n = WAIT_B; end
            2'b10:   begin capture = 1'b1; state_n = WAIT_A; end
            default: ;
          endcase
        end else begin
          issue = need_a ? INP_VALID[0] : INP_VALID[1];
        end
      end
      WAIT_A, WAIT_B: begin
        if ((state == WAIT_A) ? INP_VALID[0] : INP_VALID[1]) begin
          issue = 1'b1;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          time_out = 1'b1;
          state_n  = IDLE;
        end else begin
          tick_t = 1'b1;
        end
      end
      MUL: begin
        if (mcnt == MW'(MUL_LAT - 1)) begin
          mul_done = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (issue) state_n = is_mul ? MUL : IDLE;
  end

  assign READY = (state != MUL);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      timer     <= '0;
      mcnt      <= '0;
      lat_a     <= '0;
      lat_b     <= '0;
      lat_cmd   <= '0;
      lat_mode  <= 1'b0;
      lat_cin   <= 1'b0;
      mul_prod  <= '0;
      RES_VALID <= 1'b0;
      RES       <= '0;
      COUT      <= 1'b0;
      OFLOW     <= 1'b0;
      G         <= 1'b0;
      E         <= 1'b0;
      L         <= 1'b0;
      ERR       <= 1'b0;
    end else if (!CE) begin
      RES_VALID <= 1'b0;
    end else begin
      state     <= state_n;
      RES_VALID <= 1'b0;
      if (capture) begin
        lat_a    <= OPA;
        lat_b    <= OPB;
        lat_cmd  <= CMD;
        lat_mode <= MODE;
        lat_cin  <= CIN;
        timer    <= '0;
      end
      if (tick_t) timer <= timer + 1'b1;
      if (state == MUL && !mul_done) mcnt <= mcnt + 1'b1;
      if (issue && is_mul) begin
        mul_prod <= x_res;
        mcnt     <= '0;
      end else if (issue) begin
        RES       <= x_res;
        COUT      <= x_cout;
        OFLOW     <= x_oflow;
        G         <= x_g;
        E         <= x_e;
        L         <= x_l;
        ERR       <= x_err;
        RES_VALID <= 1'b1;
      end else if (time_out || mul_done) begin
        RES       <= time_out ? '0 : mul_prod;
        COUT      <= 1'b0;
        OFLOW     <= 1'b0;
        G         <= 1'b0;
        E         <= 1'b0;
        L         <= 1'b0;
        ERR       <= time_out;
        RES_VALID <= 1'b1;
      end
    end
  end

endmodule
